// File: rtl/coeff_update_sched_pkg.sv
// Shared definitions for the biquad coefficient update scheduler:
// FSM state encoding, coefficient width, the zero coefficient and the
// coefficient-generator pipeline latency.
package coeff_pkg;

  localparam int FP_W       = 64;
  localparam logic [FP_W-1:0] FP_ZERO = 64'h0;
  localparam int DP_LATENCY = 48;
  localparam int N_COEFF    = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_ARMED   = 3'd4
  } state_e;

endpackage

// File: rtl/coeff_update_sched_bank.sv
// One bank of the five biquad coefficients (b0, b1, b2, a1, a2) with a
// synchronous clear and a single load enable so all five move together.
module coeff_bank #(
  parameter int W = coeff_pkg::FP_W
) (
  input  logic                                 clk,
  input  logic                                 clr_i,
  input  logic                                 load_i,
  input  logic [coeff_pkg::N_COEFF-1:0][W-1:0] d_i,
  output logic [coeff_pkg::N_COEFF-1:0][W-1:0] q_o
);
  import coeff_pkg::*;

  logic [N_COEFF-1:0][W-1:0] bank_q;

  // Clear to silence, otherwise load all five coefficients at once or hold.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < N_COEFF; i++) begin
        bank_q[i] <= W'(FP_ZERO);
      end
    end else if (load_i) begin
      bank_q <= d_i;
    end else begin
      bank_q <= bank_q;
    end
  end

  assign q_o = bank_q;

endmodule

// File: rtl/coeff_update_sched.sv
// Coefficient update scheduler: takes a new K, launches it into the
// free-running coefficient pipeline, waits the pipeline latency, captures
// the results into a shadow bank and commits them to the active bank on
// the next audio sample boundary, so the filter never sees a mixed set.
module coeff_update_sched #(
  parameter int K_W     = 18,
  parameter int FP_W    = coeff_pkg::FP_W,
  parameter int LATENCY = coeff_pkg::DP_LATENCY,
  parameter int CNT_W   = 6
) (
  input  logic            clk_fast,
  input  logic            rst,
  input  logic [K_W-1:0]  k_fixed,
  input  logic            k_valid,
  output logic            k_ready,
  input  logic            sample_strobe,
  output logic [K_W-1:0]  dp_k,
  output logic            dp_start,
  input  logic [FP_W-1:0] dp_b0,
  input  logic [FP_W-1:0] dp_b1,
  input  logic [FP_W-1:0] dp_b2,
  input  logic [FP_W-1:0] dp_a1,
  input  logic [FP_W-1:0] dp_a2,
  output logic [FP_W-1:0] b0,
  output logic [FP_W-1:0] b1,
  output logic [FP_W-1:0] b2,
  output logic [FP_W-1:0] a1,
  output logic [FP_W-1:0] a2,
  output logic            coeff_valid,
  output logic            commit,
  output logic            busy
);
  import coeff_pkg::*;

  if (LATENCY < 2 || (2 ** CNT_W) <= LATENCY) begin : g_bad_cfg
    $error("coeff_update_sched: LATENCY must be >= 2 and < 2**CNT_W");
  end

  state_e                    state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      pend_v_q;
  logic [K_W-1:0]            pend_k_q;
  logic [K_W-1:0]            last_k_q;
  logic [K_W-1:0]            dp_k_q;
  logic                      dp_start_q;
  logic                      commit_q;
  logic                      coeff_valid_q;
  logic                      busy_q;
  logic                      xfer_s;
  logic                      redundant_s;
  logic                      shadow_ld_s;
  logic                      active_ld_s;
  logic [N_COEFF-1:0][FP_W-1:0] dp_vec_s;
  logic [N_COEFF-1:0][FP_W-1:0] shadow_s;
  logic [N_COEFF-1:0][FP_W-1:0] active_s;

  assign k_ready     = ~pend_v_q & ~rst;
  assign xfer_s      = k_valid & k_ready;
  assign redundant_s = coeff_valid_q & (pend_k_q == last_k_q);
  assign shadow_ld_s = (state_q == ST_CAPTURE);
  assign active_ld_s = (state_q == ST_ARMED) & sample_strobe;
  assign dp_vec_s    = {dp_a2, dp_a1, dp_b2, dp_b1, dp_b0};

  // One-deep pending request slot: filled on a handshake, drained in IDLE.
  always_ff @(posedge clk_fast) begin
    if (rst) begin
      pend_v_q <= 1'b0;
      pend_k_q <= {K_W{1'b0}};
    end else if (xfer_s) begin
      pend_v_q <= 1'b1;
      pend_k_q <= k_fixed;
    end else if (state_q == ST_IDLE && pend_v_q) begin
      pend_v_q <= 1'b0;
    end else begin
      pend_v_q <= pend_v_q;
    end
  end

  // Launch / wait / capture / arm sequencer with registered strobes.
  always_ff @(posedge clk_fast) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= {CNT_W{1'b0}};
      dp_k_q        <= {K_W{1'b0}};
      last_k_q      <= {K_W{1'b0}};
      dp_start_q    <= 1'b0;
      commit_q      <= 1'b0;
      coeff_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      dp_start_q <= 1'b0;
      commit_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pend_v_q && !redundant_s) begin
            dp_k_q     <= pend_k_q;
            cnt_q      <= {CNT_W{1'b0}};
            dp_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_LAUNCH;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_LAUNCH: begin
          cnt_q   <= cnt_q + CNT_W'(1);
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(LATENCY - 1)) begin
            state_q <= ST_CAPTURE;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_CAPTURE: begin
          last_k_q <= dp_k_q;
          state_q  <= ST_ARMED;
        end
        ST_ARMED: begin
          if (sample_strobe) begin
            coeff_valid_q <= 1'b1;
            commit_q      <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= ST_IDLE;
          end else begin
            state_q <= ST_ARMED;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  coeff_bank #(.W(FP_W)) u_shadow (
    .clk    (clk_fast),
    .clr_i  (rst),
    .load_i (shadow_ld_s),
    .d_i    (dp_vec_s),
    .q_o    (shadow_s)
  );

  coeff_bank #(.W(FP_W)) u_active (
    .clk    (clk_fast),
    .clr_i  (rst),
    .load_i (active_ld_s),
    .d_i    (shadow_s),
    .q_o    (active_s)
  );

  assign dp_k        = dp_k_q;
  assign dp_start    = dp_start_q;
  assign commit      = commit_q;
  assign coeff_valid = coeff_valid_q;
  assign busy        = busy_q;
  assign b0          = active_s[0];
  assign b1          = active_s[1];
  assign b2          = active_s[2];
  assign a1          = active_s[3];
  assign a2          = active_s[4];

endmodule

// File: tb/tb_coeff_update_sched.sv
// Self-checking bench for coeff_update_sched: a constant vector table for the
// basic request/commit/redundant flow, hand-written corner sequences, and a
// random phase, all checked each cycle against a timestamp-based model.
module tb_coeff_update_sched;

  localparam int K_W = 18;
  localparam int FP_W = 64;
  localparam int LAT = 48;

  logic            clk_fast = 1'b0;
  logic            rst = 1'b1;
  logic [K_W-1:0]  k_fixed = '0;
  logic            k_valid = 1'b0;
  logic            k_ready;
  logic            sample_strobe = 1'b0;
  logic [K_W-1:0]  dp_k;
  logic            dp_start;
  logic [FP_W-1:0] dp_b0 = '0, dp_b1 = '0, dp_b2 = '0, dp_a1 = '0, dp_a2 = '0;
  logic [FP_W-1:0] b0, b1, b2, a1, a2;
  logic            coeff_valid, commit, busy;

  coeff_update_sched #(.K_W(K_W), .FP_W(FP_W), .LATENCY(LAT), .CNT_W(6)) dut (
    .clk_fast(clk_fast), .rst(rst), .k_fixed(k_fixed), .k_valid(k_valid),
    .k_ready(k_ready), .sample_strobe(sample_strobe), .dp_k(dp_k),
    .dp_start(dp_start), .dp_b0(dp_b0), .dp_b1(dp_b1), .dp_b2(dp_b2),
    .dp_a1(dp_a1), .dp_a2(dp_a2), .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2),
    .coeff_valid(coeff_valid), .commit(commit), .busy(busy)
  );

  always #5 clk_fast = ~clk_fast;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int n_commit = 0;

  // Reference model: request slot, timestamps for the capture edge, banks.
  bit             m_pend_v, m_busy, m_armed, m_valid, m_start, m_commit;
  logic [K_W-1:0] m_pend_k, m_last_k, m_dpk;
  int             m_cap_edge;
  logic [FP_W-1:0] m_sh [5];
  logic [FP_W-1:0] m_act [5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d actual=%h expected=%h", nm, edge_n, act, exp);
    end
  endtask

  function automatic logic [FP_W-1:0] dpval(input int idx, input int e);
    logic [7:0]  tag;
    logic [55:0] stamp;
    tag   = 8'(idx + 1);
    stamp = 56'(e) * 56'd977 + 56'(idx);
    return {tag, stamp};
  endfunction

  task automatic model_reset();
    m_pend_v = 0; m_busy = 0; m_armed = 0; m_valid = 0; m_start = 0; m_commit = 0;
    m_pend_k = '0; m_last_k = '0; m_dpk = '0; m_cap_edge = -1;
    for (int i = 0; i < 5; i++) begin m_sh[i] = '0; m_act[i] = '0; end
  endtask

  // Apply one clock edge, advance the model with the inputs seen at that
  // edge, then compare every output a little after the edge.
  task automatic step();
    logic [FP_W-1:0] dpv [5];
    bit xfer;
    dp_b0 = dpval(0, edge_n); dp_b1 = dpval(1, edge_n); dp_b2 = dpval(2, edge_n);
    dp_a1 = dpval(3, edge_n); dp_a2 = dpval(4, edge_n);
    dpv[0] = dp_b0; dpv[1] = dp_b1; dpv[2] = dp_b2; dpv[3] = dp_a1; dpv[4] = dp_a2;
    @(posedge clk_fast);
    if (rst) begin
      model_reset();
    end else begin
      xfer = k_valid && !m_pend_v;
      m_start = 0;
      m_commit = 0;
      if (!m_busy) begin
        if (m_pend_v) begin
          m_pend_v = 0;
          if (!(m_valid && m_pend_k == m_last_k)) begin
            m_dpk = m_pend_k; m_busy = 1; m_armed = 0; m_start = 1;
            m_cap_edge = edge_n + 1 + LAT;
          end
        end
      end else if (!m_armed) begin
        if (edge_n == m_cap_edge) begin
          for (int i = 0; i < 5; i++) m_sh[i] = dpv[i];
          m_last_k = m_dpk;
          m_armed = 1;
        end
      end else if (sample_strobe) begin
        for (int i = 0; i < 5; i++) m_act[i] = m_sh[i];
        m_valid = 1; m_commit = 1; m_busy = 0; m_armed = 0;
      end
      if (xfer) begin
        m_pend_v = 1;
        m_pend_k = k_fixed;
      end
    end
    edge_n++;
    #1;
    if (commit === 1'b1) n_commit++;
    chk("k_ready", 64'(k_ready), 64'(!m_pend_v && !rst));
    chk("dp_start", 64'(dp_start), 64'(m_start));
    chk("dp_k", 64'(dp_k), 64'(m_dpk));
    chk("commit", 64'(commit), 64'(m_commit));
    chk("coeff_valid", 64'(coeff_valid), 64'(m_valid));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("b0", b0, m_act[0]);
    chk("b1", b1, m_act[1]);
    chk("b2", b2, m_act[2]);
    chk("a1", a1, m_act[3]);
    chk("a2", a2, m_act[4]);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    int             n;
    bit             rst;
    bit             kv;
    logic [K_W-1:0] kf;
    bit             ss;
    bit             e_busy;
    bit             e_start;
    bit             e_commit;
    bit             e_valid;
    bit             e_kready;
    logic [K_W-1:0] e_dpk;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int c0;
    logic [K_W-1:0] pick [4];
    model_reset();
    // n, rst, kv, kf, ss | busy, start, commit, valid, kready, dp_k
    tbl[0] = '{2,  1'b1, 1'b0, 18'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h00000};
    tbl[1] = '{1,  1'b0, 1'b1, 18'h00C00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h00000};
    tbl[2] = '{1,  1'b0, 1'b0, 18'h00000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 18'h00C00};
    tbl[3] = '{1,  1'b0, 1'b0, 18'h00000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 18'h00C00};
    tbl[4] = '{48, 1'b0, 1'b0, 18'h00000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 18'h00C00};
    tbl[5] = '{1,  1'b0, 1'b0, 18'h00000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 18'h00C00};
    tbl[6] = '{1,  1'b0, 1'b0, 18'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 18'h00C00};
    tbl[7] = '{1,  1'b0, 1'b1, 18'h00C00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 18'h00C00};
    tbl[8] = '{1,  1'b0, 1'b0, 18'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 18'h00C00};
    tbl[9] = '{3,  1'b0, 1'b0, 18'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 18'h00C00};

    for (int v = 0; v < 10; v++) begin
      rst = tbl[v].rst; k_valid = tbl[v].kv; k_fixed = tbl[v].kf;
      sample_strobe = tbl[v].ss;
      steps(tbl[v].n);
      chk($sformatf("tbl%0d_busy", v), 64'(busy), 64'(tbl[v].e_busy));
      chk($sformatf("tbl%0d_start", v), 64'(dp_start), 64'(tbl[v].e_start));
      chk($sformatf("tbl%0d_commit", v), 64'(commit), 64'(tbl[v].e_commit));
      chk($sformatf("tbl%0d_valid", v), 64'(coeff_valid), 64'(tbl[v].e_valid));
      chk($sformatf("tbl%0d_kready", v), 64'(k_ready), 64'(tbl[v].e_kready));
      chk($sformatf("tbl%0d_dpk", v), 64'(dp_k), 64'(tbl[v].e_dpk));
    end
    sample_strobe = 0; k_valid = 0;

    // Queued request during WAIT, strobes sprinkled through WAIT.
    c0 = n_commit;
    k_valid = 1; k_fixed = 18'h00800; step();
    k_valid = 0; steps(10);
    k_valid = 1; k_fixed = 18'h01000; step();
    k_valid = 0;
    for (int i = 0; i < 160; i++) begin
      sample_strobe = (i % 13 == 5);
      step();
    end
    sample_strobe = 0;
    chk("queued_commits", 64'(n_commit - c0), 64'd2);
    chk("queued_last_dpk", 64'(dp_k), 64'h01000);

    // Strobe held off for 1000 cycles while ARMED.
    c0 = n_commit;
    k_valid = 1; k_fixed = 18'h02000; step();
    k_valid = 0; steps(60);
    steps(1000);
    chk("holdoff_no_commit", 64'(n_commit - c0), 64'd0);
    chk("holdoff_busy", 64'(busy), 64'd1);
    sample_strobe = 1; step();
    sample_strobe = 0;
    chk("holdoff_commit", 64'(commit), 64'd1);
    steps(2);

    // Reset in WAIT, then reset in ARMED: nothing commits afterwards.
    for (int r = 0; r < 2; r++) begin
      c0 = n_commit;
      k_valid = 1; k_fixed = 18'h03000 + 18'(r); step();
      k_valid = 0; steps(r == 0 ? 20 : 60);
      rst = 1; step();
      chk("rst_valid", 64'(coeff_valid), 64'd0);
      chk("rst_b0", b0, 64'h0);
      chk("rst_kready_low", 64'(k_ready), 64'd0);
      rst = 0; #1;
      chk("rst_kready_high", 64'(k_ready), 64'd1);
      for (int i = 0; i < 80; i++) begin
        sample_strobe = (i % 9 == 0);
        step();
      end
      sample_strobe = 0;
      chk("rst_no_commit", 64'(n_commit - c0), 64'd0);
    end

    // Randomised traffic against the model.
    pick[0] = 18'h00C00; pick[1] = 18'h00800; pick[2] = 18'h01000;
    for (int i = 0; i < 3000; i++) begin
      pick[3] = 18'($urandom);
      k_valid = ($urandom_range(0, 15) == 0);
      k_fixed = pick[$urandom_range(0, 3)];
      sample_strobe = ($urandom_range(0, 24) == 0);
      rst = ($urandom_range(0, 799) == 0);
      step();
    end
    rst = 0; k_valid = 0; sample_strobe = 0;
    steps(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coeff_update_sched.md
Name: coeff_update_sched

Overview:
- Sequences the biquad coefficient generator: accepts a new fixed-point K, launches it into the free-running FP pipeline, and waits the fixed pipeline latency.
- Captures b0/b1/b2/a1/a2 into a shadow bank, then commits them to the active bank on the next audio sample boundary.
- Replaces the free-running counter/reg_en scheme, so the filter never sees a half-updated coefficient set.

Parameters:
- K_W, 18, width of fixed-point K input.
- FP_W, 64, width of each double-precision coefficient.
- LATENCY, 48, cycles from a stable dp_k at the datapath input to stable dp_* outputs. Minimum 2.
- CNT_W, 6, latency counter width. Must satisfy 2**CNT_W > LATENCY.

Ports:
- clk_fast  in  1  sole clock; all logic is on its rising edge.
- rst  in  1  synchronous reset, active-high.
- k_fixed  in  K_W  requested K (21 fractional bits after zero-extension in the datapath).
- k_valid  in  1  k_fixed request valid.
- k_ready  out  1  pending slot free; a transfer happens when k_valid and k_ready are both high.
- sample_strobe  in  1  one-cycle pulse at each audio sample boundary, already synchronised to clk_fast.
- dp_k  out  K_W  K driven to the coefficient datapath; held stable while busy.
- dp_start  out  1  one-cycle pulse in the LAUNCH cycle.
- dp_b0, dp_b1, dp_b2, dp_a1, dp_a2  in  FP_W each  datapath results.
- b0, b1, b2, a1, a2  out  FP_W each  active coefficients to the biquad.
- coeff_valid  out  1  high once the first commit has happened.
- commit  out  1  one-cycle pulse on the cycle the active bank is updated.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (rst high at an edge):
  - state=IDLE; pend_v, dp_start, commit, coeff_valid cleared; dp_k=0; last_k=0.
  - Shadow and active banks cleared to 64'h0, so the filter outputs silence.
  - k_ready is low while rst is high.
- Reset mid-operation abandons any computation and any armed shadow bank. No commit follows.
- Pending slot:
  - k_ready = ~pend_v & ~rst.
  - On a transfer, pend_k<=k_fixed and pend_v<=1.
  - The slot is one deep and is never overwritten.
- IDLE:
  - If pend_v is set and coeff_valid is set and pend_k==last_k: clear pend_v and stay in IDLE. This is a redundant request; no launch and no commit.
  - Else if pend_v is set: dp_k<=pend_k, clear pend_v, counter<=0, go to LAUNCH.
- LAUNCH (1 cycle): dp_start=1, counter increments, go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - When counter==LATENCY-1 at an edge, go to CAPTURE.
  - The CAPTURE cycle is therefore exactly LATENCY cycles after the LAUNCH cycle.
- CAPTURE (1 cycle): shadow<=dp_* and last_k<=dp_k, then go to ARMED.
- ARMED:
  - Wait for sample_strobe.
  - On the strobe edge: active<=shadow, coeff_valid<=1, go to IDLE.
  - commit is high for the one cycle after that edge.
- sample_strobe is ignored in IDLE, LAUNCH, WAIT and CAPTURE.
- A strobe in the same cycle ARMED is entered is not seen. The strobe must arrive while the state is ARMED.
- New k during LAUNCH/WAIT/CAPTURE/ARMED: accepted into the pending slot if it is free, and processed after the current commit. No abort, no supersede.
- Simultaneous transfer and IDLE decision: the IDLE decision uses the registered pend_v, so a request accepted this cycle is acted on next cycle.
- dp_k changes only on the IDLE→LAUNCH edge.
- Active outputs change only on commit, so all five coefficients update atomically.
- Latency: transfer at edge 0 gives LAUNCH in cycle 2, CAPTURE in cycle 2+LATENCY, and ARMED from cycle 3+LATENCY. The commit edge is the first strobe seen from then on.
- Counter does not wrap (LATENCY < 2**CNT_W is checked at elaboration).

Decomposition:
- Shared package coeff_pkg holds:
  - state encoding (IDLE, LAUNCH, WAIT, CAPTURE, ARMED);
  - FP_W;
  - FP_ZERO=64'h0;
  - datapath latency constant, used as the LATENCY default so it stays consistent with the coefficient generator.
- Sub-module coeff_bank: five FP_W registers with a synchronous clear and a single load enable. It is instantiated twice, as shadow and active.

Test Plan:
- Reset then k_fixed=18'h00C00 with k_valid=1 at cycle 0: dp_start pulses in cycle 2 with dp_k=18'h00C00; shadow captures in cycle 50 (LATENCY=48); first sample_strobe after that gives commit=1, b0..a2 = datapath values, coeff_valid=1.
- Second request 18'h00C00 after that commit: no dp_start, busy stays low, outputs unchanged.
- k=18'h01000 issued during WAIT of an earlier k=18'h00800: k_ready falls and stays low until LAUNCH of 18'h01000. That LAUNCH follows the 18'h00800 commit, so two commits occur in order with no intermediate mixing.
- Strobes during WAIT: no commit and active bank unchanged. Strobe held off 1000 cycles while ARMED: active bank is stable and commit comes only on the strobe.
- rst asserted in WAIT (and separately in ARMED): all outputs are 0 next cycle, no commit afterwards, and k_ready returns high the cycle after rst is released.
- Datapath model with dp_* changing every cycle: the captured shadow equals the model value exactly LATENCY cycles after LAUNCH, and the values change every cycle so an off-by-one latency is caught.
